// File: rtl/lsu_defs.sv
// rtl/lsu_defs.sv - shared constants and helpers for the load/store unit
// Contents: memi bit positions, func3 codes, FSM state encodings,
//           byte-enable and write-lane helpers.
package lsu_defs;

  localparam int MEMI_LD = 4;
  localparam int MEMI_ST = 3;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  // func3[1:0] is the access size for every legal load/store encoding.
  function automatic logic [3:0] be_for(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'd0:    be_for = 4'b0001 << a;
      2'd1:    be_for = a[1] ? 4'b1100 : 4'b0011;
      default: be_for = 4'b1111;
    endcase
  endfunction

  // Narrow stores are replicated so the selected byte lanes carry the data
  // regardless of address offset.
  function automatic logic [31:0] wdata_for(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'd0:    wdata_for = {4{wd[7:0]}};
      2'd1:    wdata_for = {2{wd[15:0]}};
      default: wdata_for = wd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// rtl/lsu_load_extend.sv - lane select and sign/zero extension of a bus read word
// Ports: m_rdata (bus word), addr_lo (byte offset), func3 (load type),
//        result (extended 32-bit load value).
module lsu_load_extend
  import lsu_defs::*;
(
  input  logic [31:0] m_rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  output logic [31:0] result
);

  logic [15:0] lane;

  always_comb begin
    lane = 16'(m_rdata >> {addr_lo, 3'b000});
    case (func3)
      F3_B:    result = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   result = {24'b0, lane[7:0]};
      F3_H:    result = {{16{lane[15]}}, lane};
      F3_HU:   result = {16'b0, lane};
      F3_W:    result = m_rdata;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit driving a req/ack data-memory bus
// Optional feature macro: LSU_TIMEOUT_EN (abort REQ after TIMEOUT_CYCLES without ack).
// Ports: clk, rst (sync active-high); core side valid_i, memi, addr_i, wdata_i,
//        stall, done, err, rdata; bus side m_req, m_we, m_be, m_addr, m_wdata,
//        m_rdata, m_ack.
module lsu_mem_ctrl
  import lsu_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned AW             = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [4:0]    memi,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic          stall,
  output logic          done,
  output logic          err,
  output logic [31:0]   rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [3:0]    m_be,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata,
  input  logic          m_ack
);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    func3_q, func3_d;
  logic          is_store_q, is_store_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          ld, st, access, illegal, misaligned;
  logic [2:0]    f3;
  logic [31:0]   ext_data;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  lsu_load_extend u_ext (
    .m_rdata (m_rdata),
    .addr_lo (addr_q[1:0]),
    .func3   (func3_q),
    .result  (ext_data)
  );

  always_comb begin
    ld     = memi[MEMI_LD];
    st     = memi[MEMI_ST];
    f3     = memi[2:0];
    access = valid_i & (ld | st);

    misaligned = ((f3[1:0] == 2'd1) & addr_i[0]) |
                 ((f3[1:0] == 2'd2) & (addr_i[1:0] != 2'b00));
    illegal = (ld & st) |
              (ld & ((f3 == 3'd3) | (f3 == 3'd6) | (f3 == 3'd7))) |
              (st & (f3 >= 3'd3)) |
              misaligned;

    state_d    = state_q;
    addr_d     = addr_q;
    func3_d    = func3_q;
    is_store_d = is_store_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (illegal) begin
            state_d = ST_ERR;
          end else begin
            state_d    = ST_REQ;
            addr_d     = addr_i;
            func3_d    = f3;
            is_store_d = st;
            be_d       = be_for(f3, addr_i[1:0]);
            wdata_d    = wdata_for(f3, wdata_i);
`ifdef LSU_TIMEOUT_EN
            cnt_d      = '0;
`endif
          end
        end
      end
      ST_REQ: begin
        // An ack coinciding with expiry takes priority over the timeout.
        if (m_ack) begin
          state_d = ST_DONE;
          if (!is_store_q) rdata_d = ext_data;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      func3_q    <= '0;
      is_store_q <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      func3_q    <= func3_d;
      is_store_q <= is_store_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Bus outputs come straight from flops, gated by REQ so they read zero
  // whenever no transaction is in flight.
  always_comb begin
    m_req   = (state_q == ST_REQ);
    m_we    = m_req & is_store_q;
    m_be    = m_req ? be_q : 4'b0000;
    m_addr  = m_req ? {addr_q[AW-1:2], 2'b00} : '0;
    m_wdata = m_req ? wdata_q : '0;
    done    = (state_q == ST_DONE);
    err     = (state_q == ST_ERR);
    stall   = ((state_q == ST_IDLE) & access) | m_req;
    rdata   = rdata_q;
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [4:0]  memi;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall, done, err, m_req, m_we, m_ack;
  logic [31:0] rdata, m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_rdata = 32'h0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(4), .AW(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .memi(memi), .addr_i(addr_i),
    .wdata_i(wdata_i), .stall(stall), .done(done), .err(err), .rdata(rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit ref_illegal(input logic [4:0] mi, input logic [31:0] a);
    logic [2:0] f3;
    f3 = mi[2:0];
    if (mi[4] && mi[3]) return 1;
    if (mi[4] && (f3 == 3 || f3 == 6 || f3 == 7)) return 1;
    if (mi[3] && f3 >= 3) return 1;
    return (a % nbytes_of(f3)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = nbytes_of(f3);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    longint unsigned unit, acc;
    int n;
    n = nbytes_of(f3);
    unit = longint'(wd) & ((64'd1 << (8 * n)) - 1);
    acc = 0;
    for (int k = 0; k < 4 / n; k++) acc = acc | (unit << (8 * n * k));
    return acc[31:0];
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
    longint v;
    int bits;
    bits = 8 * nbytes_of(f3);
    v = (longint'(w) >> (8 * (a % 4))) & ((64'd1 << bits) - 1);
    if (f3 < 4 && bits < 32 && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  // Entered and left at posedge+1. dly = REQ cycles before the ack cycle.
  task automatic run_access(input logic [4:0] mi, input logic [31:0] a,
                            input logic [31:0] wd, input int dly, input logic [31:0] rd);
    valid_i = 1'b1; memi = mi; addr_i = a; wdata_i = wd;
    #1 chk("stall_detect", 32'(stall), 32'd1);
    @(posedge clk); #1;
    valid_i = 1'b0; memi = 5'b0;
    if (ref_illegal(mi, a)) begin
      chk("err_pulse", 32'(err), 32'd1);
      chk("err_no_req", 32'(m_req), 32'd0);
      chk("err_stall", 32'(stall), 32'd0);
      chk("err_rdata", rdata, model_rdata);
      @(posedge clk); #1;
      chk("err_clear", 32'(err), 32'd0);
    end else begin
      for (int i = 0; i <= dly; i++) begin
        chk("req_m_req", 32'(m_req), 32'd1);
        chk("req_m_we", 32'(m_we), 32'(mi[3]));
        chk("req_m_be", 32'(m_be), 32'(ref_be(mi[2:0], a)));
        chk("req_m_addr", m_addr, a & 32'hFFFF_FFFC);
        if (mi[3]) chk("req_m_wdata", m_wdata, ref_wdata(mi[2:0], wd));
        chk("req_stall", 32'(stall), 32'd1);
        if (i == dly) begin m_ack = 1'b1; m_rdata = rd; end
        @(posedge clk); #1;
      end
      m_ack = 1'b0;
      if (mi[4]) model_rdata = ref_load(rd, a, mi[2:0]);
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_m_req", 32'(m_req), 32'd0);
      chk("done_stall", 32'(stall), 32'd0);
      chk("done_rdata", rdata, model_rdata);
      @(posedge clk); #1;
      chk("done_clear", 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [4:0]  mi;
    logic [31:0] a;
    rst = 1'b1; valid_i = 1'b0; memi = 5'b0; addr_i = '0; wdata_i = '0;
    m_ack = 1'b0; m_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_be", 32'(m_be), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    run_access(5'b10010, 32'h100, 32'h0, 0, 32'hDEADBEEF);           // LW
    chk("lw_value", rdata, 32'hDEADBEEF);
    run_access(5'b10000, 32'h203, 32'h0, 1, 32'h80112233);           // LB
    chk("lb_value", rdata, 32'hFFFFFF80);
    run_access(5'b10100, 32'h203, 32'h0, 0, 32'h80112233);           // LBU
    chk("lbu_value", rdata, 32'h00000080);
    run_access(5'b01001, 32'h302, 32'h0000ABCD, 2, 32'h12345678);    // SH
    chk("sh_rdata_kept", rdata, 32'h00000080);
    run_access(5'b10010, 32'h101, 32'h0, 0, 32'h0);                  // misaligned LW
    run_access(5'b11000, 32'h200, 32'h0, 0, 32'h0);                  // load+store

    // Randomized accesses against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic [1:0] ls;
      ls = 2'($urandom_range(1, 3));
      mi = {ls, 3'($urandom_range(0, 7))};
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~32'(nbytes_of(mi[2:0]) - 1);
      run_access(mi, a, $urandom, $urandom_range(0, 3), $urandom);
    end

    // Reset in the middle of a slow transaction.
    valid_i = 1'b1; memi = 5'b10010; addr_i = 32'h40;
    @(posedge clk); #1;
    valid_i = 1'b0; memi = 5'b0;
    chk("rstmid_req1", 32'(m_req), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_rdata = 32'h0;
    chk("rstmid_m_req", 32'(m_req), 32'd0);
    chk("rstmid_m_we_be", {27'd0, m_we, m_be}, 32'd0);
    chk("rstmid_m_addr", m_addr, 32'd0);
    chk("rstmid_m_wdata", m_wdata, 32'd0);
    chk("rstmid_rdata", rdata, 32'd0);
    chk("rstmid_flags", {29'd0, done, err, stall}, 32'd0);
    m_ack = 1'b1; m_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    m_ack = 1'b0;
    chk("stray_ack_done", 32'(done), 32'd0);
    chk("stray_ack_req", 32'(m_req), 32'd0);
    chk("stray_ack_rdata", rdata, 32'd0);
    run_access(5'b01000, 32'h401, 32'h000000A5, 0, 32'h0);           // SB
    chk("sb_rdata_kept", rdata, 32'd0);

`ifdef LSU_TIMEOUT_EN
    for (int v = 0; v < 2; v++) begin
      valid_i = 1'b1; memi = 5'b10010; addr_i = 32'h500;
      @(posedge clk); #1;
      valid_i = 1'b0; memi = 5'b0;
      for (int c = 0; c < 4; c++) begin
        chk("to_m_req", 32'(m_req), 32'd1);
        if (v == 1 && c == 3) begin m_ack = 1'b1; m_rdata = 32'h01020304; end
        @(posedge clk); #1;
      end
      m_ack = 1'b0;
      chk("to_m_req_low", 32'(m_req), 32'd0);
      chk("to_err", 32'(err), (v == 0) ? 32'd1 : 32'd0);
      chk("to_done", 32'(done), (v == 1) ? 32'd1 : 32'd0);
      if (v == 1) model_rdata = 32'h01020304;
      chk("to_rdata", rdata, model_rdata);
      @(posedge clk); #1;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
